cshake_prefix_encoder: RTL and testbench
========================================

# cshake_prefix_encoder

Builds the cSHAKE256 domain-separation prefix block `bytepad(encode_string(N) || encode_string(S), 136)` from a function-name string N and a customization string S. The block is assembled one byte per cycle into a 1088-bit rate block. It is offered downstream on a valid/ready handshake to the cShake256 absorb stage, which absorbs it as the first block ahead of the serial message. When both strings are empty it flags `no_prefix`, so the consumer degrades to plain SHAKE256.

## Interface
- `NMAX_BYTES`, default 16: maximum N length in bytes; must be ≤ 31.
- `SMAX_BYTES`, default 16: maximum S length in bytes; must be ≤ 31.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request to encode; sampled only in IDLE.
- `N` input 8*NMAX_BYTES: function-name bytes; byte i is at N[8i+7:8i].
- `n_len` input 5: N length in bytes, 0..NMAX_BYTES.
- `S` input 8*SMAX_BYTES: customization bytes; same byte ordering as N.
- `s_len` input 5: S length in bytes, 0..SMAX_BYTES.
- `busy` output 1: high in any state except IDLE.
- `err` output 1: one-cycle pulse when start is rejected because of an illegal length.
- `block` output 1088: prefix block; byte k is at block[8k+7:8k] (Keccak lane order).
- `block_valid` output 1: block is complete and stable.
- `block_ready` input 1: consumer accepts the block.
- `no_prefix` output 1: qualifies block_valid; both strings were empty and the block is all zero.

## Operation
- States: IDLE, BP_HDR, N_HDR, N_BODY, S_HDR, S_BODY, DONE.
- IDLE + start:
  - Latch N, S, n_len and s_len.
  - Clear the block register and the byte pointer ptr (8 bits).
  - If n_len > NMAX_BYTES or s_len > SMAX_BYTES: pulse `err`, stay in IDLE, block unchanged.
  - Else if n_len == 0 and s_len == 0: go to DONE with `no_prefix` = 1.
  - Otherwise go to BP_HDR.
- Each non-IDLE, non-DONE cycle writes exactly one byte at block[ptr], then increments ptr.
- BP_HDR writes 0x01, 0x88 (left_encode(136)).
- N_HDR writes 0x01, 8*n_len (left_encode of the bit length; n_len = 0 gives 0x01 0x00).
- N_BODY writes N bytes 0..n_len-1; it is skipped entirely when n_len = 0.
- S_HDR writes 0x01, 8*s_len.
- S_BODY writes S bytes 0..s_len-1; it is skipped when s_len = 0. On its last byte the FSM goes to DONE. When s_len = 0 that transition happens from the second S_HDR byte.
- Bytes not written stay 0x00. That zero fill is the bytepad fill; the maximum used length is 38 bytes, under 136.
- Header lengths are always one byte, because 8*31 = 248 ≤ 255. Arithmetic is 8 bits with no overflow.
- DONE: `block_valid` = 1 and `block` is held stable.
  - On block_valid && block_ready the FSM goes to IDLE, and block_valid and no_prefix clear on the next cycle.
  - `start` is ignored in every state except IDLE, including DONE and the handshake cycle.
- `block_ready` held low keeps DONE indefinitely.
- Reset has priority over everything, including mid-encode and during DONE. It returns the FSM to IDLE and drives all outputs to 0.

## Timing
- Reset values: busy = 0, err = 0, block = 0, block_valid = 0, no_prefix = 0.
- Latency: with start sampled on edge E0, block_valid is high after edge E(6+n_len+s_len).
- For the empty/empty case, block_valid is high after E1.
- Throughput: one prefix per 7+n_len+s_len cycles plus handshake wait. There is no back-to-back overlap.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- `cshake_pkg` contains:
  - RATE_BYTES = 136 and RATE_BITS = 1088.
  - The FSM state enum.
  - Function `left_encode1(byte)`, returning the 16-bit pair {0x01, x}.
- The cShake256 absorb stage imports the same package constants.
- No sub-module: the FSM, pointer and byte-write demux stay in one module.

## Test plan
- N empty, S = "Email Signature" (15 bytes), start → after 21 edges block bytes 0..20 = 01 88 01 00 01 78 45 6D 61 69 6C 20 53 69 67 6E 61 74 75 72 65, all other bytes 0, no_prefix = 0.
- N = 0x4B (n_len = 1), S empty → after 7 edges bytes = 01 88 01 08 4B 01 00, rest 0.
- n_len = 0, s_len = 0 → after 1 edge block_valid = 1, no_prefix = 1, block = 0. Ready pulse → block_valid = 0 the next cycle.
- n_len = 17, start → err high for exactly 1 cycle, busy stays 0, block_valid stays 0.
- block_ready held low for 10 cycles in DONE, with start pulsed meanwhile → block is stable and start is ignored. Ready = 1 → IDLE; a new start then encodes correctly.
- Reset asserted in N_BODY with N = 16 bytes → next cycle all outputs are 0. A fresh start then gives a clean block with no stale bytes.

Source files
------------

// File: rtl/cshake_pkg.sv
// Shared cSHAKE256 constants, the prefix-encoder FSM states and the one-byte left_encode helper.
// The absorb stage imports RATE_BYTES/RATE_BITS from here so both sides agree on the block size.
package cshake_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_BITS  = 1088;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BP_HDR = 3'd1,
    N_HDR  = 3'd2,
    N_BODY = 3'd3,
    S_HDR  = 3'd4,
    S_BODY = 3'd5,
    DONE   = 3'd6
  } state_t;

  // left_encode of a value that fits in one byte: length byte 0x01 followed by the value.
  function automatic logic [15:0] left_encode1(input logic [7:0] x);
    return {8'h01, x};
  endfunction

endpackage

// File: rtl/cshake_prefix_encoder.sv
// Assembles bytepad(encode_string(N) || encode_string(S), 136) one byte per clock; valid after 6+n_len+s_len edges (1 when both empty).
// block is held in DONE until block_ready; start is ignored outside IDLE, so a stalled consumer simply freezes the encoder.
module cshake_prefix_encoder
  import cshake_pkg::*;
#(
  parameter int NMAX_BYTES = 16,
  parameter int SMAX_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [8*NMAX_BYTES-1:0]   N,
  input  logic [4:0]                n_len,
  input  logic [8*SMAX_BYTES-1:0]   S,
  input  logic [4:0]                s_len,
  output logic                      busy,
  output logic                      err,
  output logic [RATE_BITS-1:0]      block,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic                      no_prefix
);

  state_t                    state, state_next;
  logic [4:0]                sub, sub_next;
  logic [7:0]                ptr;
  logic [RATE_BITS-1:0]      block_q;
  logic [8*NMAX_BYTES-1:0]   n_q;
  logic [8*SMAX_BYTES-1:0]   s_q;
  logic [4:0]                n_len_q, s_len_q;
  logic                      busy_q, err_q, valid_q, no_prefix_q;

  logic                      wr_en;
  logic [7:0]                wr_byte;
  logic [15:0]               hdr;
  logic                      len_bad, accept, reject, both_empty, handshake;

  assign len_bad    = (n_len > 5'(NMAX_BYTES)) || (s_len > 5'(SMAX_BYTES));
  assign accept     = (state == IDLE) && start && !len_bad;
  assign reject     = (state == IDLE) && start && len_bad;
  assign both_empty = (n_len == 5'd0) && (s_len == 5'd0);
  assign handshake  = (state == DONE) && valid_q && block_ready;

  // sub is the header byte select (0/1) in *_HDR states and the body byte index in *_BODY states.
  always_comb begin
    state_next = state;
    sub_next   = sub;
    wr_en      = 1'b0;
    wr_byte    = 8'h00;
    hdr        = 16'h0000;
    case (state)
      IDLE: begin
        sub_next = 5'd0;
        if (accept) state_next = both_empty ? DONE : BP_HDR;
      end
      BP_HDR: begin
        hdr     = left_encode1(8'(RATE_BYTES));
        wr_en   = 1'b1;
        wr_byte = sub[0] ? hdr[7:0] : hdr[15:8];
        if (sub[0]) begin
          state_next = N_HDR;
          sub_next   = 5'd0;
        end else begin
          sub_next = 5'd1;
        end
      end
      N_HDR: begin
        hdr     = left_encode1({n_len_q, 3'b000});
        wr_en   = 1'b1;
        wr_byte = sub[0] ? hdr[7:0] : hdr[15:8];
        if (sub[0]) begin
          state_next = (n_len_q == 5'd0) ? S_HDR : N_BODY;
          sub_next   = 5'd0;
        end else begin
          sub_next = 5'd1;
        end
      end
      N_BODY: begin
        wr_en   = 1'b1;
        wr_byte = n_q[{sub, 3'b000} +: 8];
        if (sub == n_len_q - 5'd1) begin
          state_next = S_HDR;
          sub_next   = 5'd0;
        end else begin
          sub_next = sub + 5'd1;
        end
      end
      S_HDR: begin
        hdr     = left_encode1({s_len_q, 3'b000});
        wr_en   = 1'b1;
        wr_byte = sub[0] ? hdr[7:0] : hdr[15:8];
        if (sub[0]) begin
          state_next = (s_len_q == 5'd0) ? DONE : S_BODY;
          sub_next   = 5'd0;
        end else begin
          sub_next = 5'd1;
        end
      end
      S_BODY: begin
        wr_en   = 1'b1;
        wr_byte = s_q[{sub, 3'b000} +: 8];
        if (sub == s_len_q - 5'd1) begin
          state_next = DONE;
          sub_next   = 5'd0;
        end else begin
          sub_next = sub + 5'd1;
        end
      end
      DONE: begin
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sub         <= 5'd0;
      ptr         <= 8'd0;
      block_q     <= '0;
      n_q         <= '0;
      s_q         <= '0;
      n_len_q     <= 5'd0;
      s_len_q     <= 5'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      no_prefix_q <= 1'b0;
    end else begin
      state  <= state_next;
      sub    <= sub_next;
      busy_q <= (state_next != IDLE);
      err_q  <= reject;
      // Entry into DONE from IDLE (empty strings) shows valid one cycle later, matching the 1-edge latency.
      valid_q <= (state_next == DONE) && (state != IDLE);

      if ((state == IDLE) && start) begin
        n_q     <= N;
        s_q     <= S;
        n_len_q <= n_len;
        s_len_q <= s_len;
        ptr     <= 8'd0;
        if (!len_bad) begin
          block_q     <= '0;
          no_prefix_q <= both_empty;
        end
      end else if (wr_en) begin
        block_q[{ptr, 3'b000} +: 8] <= wr_byte;
        ptr                         <= ptr + 8'd1;
      end

      if (handshake) no_prefix_q <= 1'b0;
    end
  end

  assign busy        = busy_q;
  assign err         = err_q;
  assign block       = block_q;
  assign block_valid = valid_q;
  assign no_prefix   = no_prefix_q;

endmodule

// File: tb/tb_cshake_prefix_encoder.sv
// Directed bench for cshake_prefix_encoder: expected prefix blocks are queued at start and checked when block_valid rises.
module tb_cshake_prefix_encoder;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [127:0]  N;
  logic [4:0]    n_len;
  logic [127:0]  S;
  logic [4:0]    s_len;
  logic          busy;
  logic          err;
  logic [1087:0] block;
  logic          block_valid;
  logic          block_ready;
  logic          no_prefix;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1087:0] blk;
    logic          np;
    int            lat;
  } exp_t;
  exp_t sb[$];

  cshake_prefix_encoder #(.NMAX_BYTES(16), .SMAX_BYTES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .N(N), .n_len(n_len), .S(S), .s_len(s_len),
    .busy(busy), .err(err), .block(block), .block_valid(block_valid),
    .block_ready(block_ready), .no_prefix(no_prefix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed low %0h expected low %0h", tag, obs[511:0], exp[511:0]);
    end
  endtask

  function automatic logic [127:0] str2b(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Reference bytepad(encode_string(N) || encode_string(S), 136) for one-byte lengths.
  function automatic logic [1087:0] model(input logic [127:0] nv, input int nl,
                                          input logic [127:0] sv, input int sl);
    logic [1087:0] b;
    int p;
    b = '0;
    p = 0;
    if (nl == 0 && sl == 0) return b;
    b[8*p +: 8] = 8'h01;        p++;
    b[8*p +: 8] = 8'd136;       p++;
    b[8*p +: 8] = 8'h01;        p++;
    b[8*p +: 8] = 8'(nl * 8);   p++;
    for (int i = 0; i < nl; i++) begin b[8*p +: 8] = nv[8*i +: 8]; p++; end
    b[8*p +: 8] = 8'h01;        p++;
    b[8*p +: 8] = 8'(sl * 8);   p++;
    for (int i = 0; i < sl; i++) begin b[8*p +: 8] = sv[8*i +: 8]; p++; end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start through edge E0 and queues the expected result.
  task automatic launch(input logic [127:0] nv, input int nl, input logic [127:0] sv, input int sl);
    exp_t e;
    N = nv; n_len = 5'(nl); S = sv; s_len = 5'(sl);
    e.blk = model(nv, nl, sv, sl);
    e.np  = (nl == 0 && sl == 0);
    e.lat = e.np ? 1 : 6 + nl + sl;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int cyc;
    cyc = 0;
    while (!block_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk({tag, "_valid"}, 32'(block_valid), 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      chk_blk({tag, "_block"}, block, e.blk);
      chk({tag, "_noprefix"}, 32'(no_prefix), 32'(e.np));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic handshake(input string tag);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(block_valid), 32'd0);
    chk({tag, "_hs_noprefix"}, 32'(no_prefix), 32'd0);
    chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1087:0] held;
    logic [55:0]   t2;
    reset = 1'b1; start = 1'b0; block_ready = 1'b0;
    N = '0; S = '0; n_len = 5'd0; s_len = 5'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(block_valid), 32'd0);
    chk("rst_noprefix", 32'(no_prefix), 32'd0);
    chk_blk("rst_block", block, '0);
    reset = 1'b0;
    tick();

    // N empty, S = "Email Signature"
    launch('0, 0, str2b("Email Signature"), 15);
    collect("email");
    handshake("email");

    // N = 0x4B, S empty; also against literal test-plan bytes
    launch(128'h4B, 1, '0, 0);
    collect("n4b");
    t2 = 56'h00_01_4B_08_01_88_01;
    chk_blk("n4b_literal", block, {1032'b0, t2});
    handshake("n4b");

    // both empty
    launch('0, 0, '0, 0);
    collect("empty");
    handshake("empty");

    // illegal n_len
    N = '1; n_len = 5'd17; S = '0; s_len = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    tick();
    chk("err_clear", 32'(err), 32'd0);
    chk("err_valid", 32'(block_valid), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);

    // hold in DONE with start pulsed, then accept and re-encode
    launch(str2b("abc"), 3, str2b("xy"), 2);
    held = model(str2b("abc"), 3, str2b("xy"), 2);
    collect("hold");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        N = str2b("ZZZZZ"); n_len = 5'd5; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk_blk("hold_block", block, held);
    chk("hold_valid", 32'(block_valid), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    handshake("hold");
    launch(str2b("KMAC"), 4, str2b("my tag"), 6);
    collect("after_hold");
    handshake("after_hold");

    // reset in N_BODY, then a full-length encode
    N = str2b("0123456789ABCDEF"); n_len = 5'd16; S = str2b("wxyz"); s_len = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_valid", 32'(block_valid), 32'd0);
    chk("mid_rst_noprefix", 32'(no_prefix), 32'd0);
    chk_blk("mid_rst_block", block, '0);
    tick();
    launch(str2b("fedcba9876543210"), 16, str2b("Sixteen byte str"), 16);
    collect("max");
    handshake("max");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
